// File: rtl/rom_read_arbiter_if.sv
// rom_read_arbiter_if: requester handshake, response and ROM-side signals of the ROM read arbiter
interface rom_read_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic [ADDR_WIDTH-1:0]         rom_addr;
  logic [DATA_WIDTH-1:0]         rom_data;
  modport slave (input req_valid, req_addr, rom_data, output req_ready, rsp_valid, rsp_data, rom_addr);
  modport master (output req_valid, req_addr, rom_data, input req_ready, rsp_valid, rsp_data, rom_addr);
endinterface

// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter: shares one single-port ROM among NUM_REQ readers; ROM_ARB_FIXED_PRI_EN selects fixed priority instead of round-robin
module rom_read_arbiter #(
  parameter int    NUM_REQ    = 4,
  parameter int    DATA_WIDTH = 16,
  parameter int    ADDR_WIDTH = 8,
  parameter string OUTPUT_REG = "FALSE"
) (
  input logic              clk,
  input logic              rst,
  rom_read_arbiter_if.slave bus
);
  localparam int ROM_LAT = (OUTPUT_REG == "TRUE") ? 2 : 1;
  localparam int LAT     = 1 + ROM_LAT;
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  logic [IW-1:0]         win;
  logic                  found;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [LAT-1:0]        vld_q, vld_d;
  logic [IW-1:0]         idx_q [LAT];
  logic [IW-1:0]         idx_d [LAT];
`ifdef ROM_ARB_FIXED_PRI_EN
  // lowest asserted index wins; scanning downward lets the lowest overwrite
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int j = NUM_REQ - 1; j >= 0; j--)
      if (bus.req_valid[j]) begin
        win   = IW'(j);
        found = 1'b1;
      end
  end
`else
  logic [IW-1:0] ptr_q, ptr_d;
  // search from ptr+1 upward with wrap; scanning farthest-first lets the nearest overwrite
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int j = NUM_REQ; j >= 1; j--)
      if (bus.req_valid[(int'(ptr_q) + j) % NUM_REQ]) begin
        win   = IW'((int'(ptr_q) + j) % NUM_REQ);
        found = 1'b1;
      end
  end
  assign ptr_d = accept ? win : ptr_q;
  // pointer starts at the last requester so requester 0 wins first
  always_ff @(posedge clk)
    if (rst) ptr_q <= IW'(NUM_REQ - 1);
    else     ptr_q <= ptr_d;
`endif
  assign accept     = found & ~rst;
  assign rom_addr_d = accept ? bus.req_addr[win*ADDR_WIDTH +: ADDR_WIDTH] : rom_addr_q;
  // tag shift register tracks owner of each in-flight read, aligned to ROM latency
  always_comb begin
    vld_d    = {vld_q[LAT-2:0], accept};
    idx_d[0] = win;
    for (int i = 1; i < LAT; i++) idx_d[i] = idx_q[i-1];
  end
  // ROM address register and tag pipeline state
  always_ff @(posedge clk)
    if (rst) begin
      rom_addr_q <= '0;
      vld_q      <= '0;
      idx_q      <= '{default: '0};
    end else begin
      rom_addr_q <= rom_addr_d;
      vld_q      <= vld_d;
      idx_q      <= idx_d;
    end
  assign bus.req_ready = accept ? NUM_REQ'(1) << win : '0;
  assign bus.rsp_valid = vld_q[LAT-1] ? NUM_REQ'(1) << idx_q[LAT-1] : '0;
  assign bus.rsp_data  = (|bus.rsp_valid) ? bus.rom_data : {DATA_WIDTH{1'b0}};
  assign bus.rom_addr  = rom_addr_q;
endmodule
